enable_table_loader: RTL and testbench
======================================

# enable_table_loader

Sequencer that fills the 512-entry RAM/bus enable table from an external configuration memory. It sits between the configuration store (SPI-flash shadow or block RAM) and the enable-table write port (`table_we` / `table_val` / `table_write_addr`). On a `start` request it copies the 128-byte image for the selected configuration into the table, one 2-bit entry per write. While it does this, it holds the CPU off the bus.

## Interface
- `CONFIG_BITS`, default 4: width of `config_sel`; number of stored configurations = 2**CONFIG_BITS.
- `CFG_ADDR_BITS`, default `CONFIG_BITS + 7`: width of the configuration-memory byte address. It must be ≥ `CONFIG_BITS + 7`.
- `fpga_clk`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  load request; sampled only in IDLE.
- `config_sel`  in  CONFIG_BITS  configuration to load; captured when `start` is accepted.
- `cfg_rd_en`  out  1  configuration-memory read strobe.
- `cfg_rd_addr`  out  CFG_ADDR_BITS  byte address = `{config_sel_q, byte_idx[6:0]}`, zero-extended.
- `cfg_rd_data`  in  8  read data, valid exactly one cycle after the `cfg_rd_en` cycle.
- `table_we`  out  1  enable-table write strobe.
- `table_write_addr`  out  9  table entry index: bit 8 = rwbar, bits 7:0 = address[15:8].
- `table_val`  out  2  entry value: {ram_cs, bus_cs}.
- `busy`  out  1  load in progress.
- `cpu_hold`  out  1  holds CPU/bus master off; equal to `busy`.
- `done`  out  1  one-cycle pulse at load completion.
- `table_valid`  out  1  the table holds a complete image.

## Operation
- States:
  - IDLE
  - RD: `cfg_rd_en`=1, address driven.
  - CAP: `cfg_rd_data` captured into an 8-bit shift register.
  - WR: 4 cycles, k = 0..3.
- Transitions:
  - IDLE → RD when `start`=1. On acceptance: `config_sel_q` ← `config_sel`, `byte_idx` ← 0, `table_valid` ← 0.
  - RD → CAP → WR(k=0).
  - WR(k) → WR(k+1) for k<3.
  - WR(3) → RD with `byte_idx`+1 if `byte_idx`≠127.
  - WR(3) → IDLE with `done`=1 and `table_valid`=1 if `byte_idx`=127.
- Packing: in byte b, entry k is `data[2k+1:2k]` and is written to `table_write_addr` = 4·b + k (9-bit).
  - Bytes 0–63 fill the write half (rwbar=0).
  - Bytes 64–127 fill the read half (rwbar=1).
- During WR, `table_we`=1 with the addr/val pair for the current k. Outside WR, `table_we`=0, and `table_write_addr`/`table_val` are 0.
- `cfg_rd_en` is 1 only in RD. `cfg_rd_addr` holds its last value outside RD.
- `start` while not IDLE: ignored, with no re-capture of `config_sel`.
- `start` in the `done` cycle: accepted, because the FSM is already IDLE. In that case `table_valid` rises in the `done` cycle and falls on the next edge.
- `byte_idx` is 7 bits and never wraps mid-load; termination is by the explicit compare to 127.
- Reset (any time, including mid-load): the FSM returns to IDLE immediately. The partially written table is not cleared, and `table_valid` is 0 until the next complete load.
- Reset values:
  - 0: `busy`, `cpu_hold`, `done`, `table_valid`, `table_we`, `cfg_rd_en`, `cfg_rd_addr`, `table_write_addr`, `table_val`.
  - Internal: `byte_idx`=0, `config_sel_q`=0.

## Timing
- Let the accepting edge be E0, and cycle n be the cycle after edge En.
- Byte b:
  - RD in cycle 1+6b.
  - CAP in cycle 2+6b, with `cfg_rd_data` sampled at the end of it.
  - WR k=0..3 in cycles 3+6b .. 6+6b.
- Last write (entry 511) is in cycle 768. `done`=1, `busy`=0 and `table_valid`=1 in cycle 769. Total: 768 busy cycles, 512 writes, 128 reads.
- `busy`/`cpu_hold` are high for cycles 1..768 inclusive.
- `done` is high for exactly one cycle.
- All outputs are registered or decoded directly from state registers; there is no combinational path from `start` or `cfg_rd_data` to any output.

## Test plan
- Reset then idle for 20 cycles → all outputs 0; `cfg_rd_en` never asserted.
- Memory preloaded so that config 3 byte b = b[7:0]; `config_sel`=3, 1-cycle `start` → first `cfg_rd_addr`=0x180, last = 0x1FF.
  - Exactly 512 `table_we` pulses; entry 4b+k = (b>>2k)&3; entry 511 = 0b01.
  - `done` in cycle 769; `table_valid`=1 thereafter.
- `start` held high and `config_sel` changed to 5 at cycle 100 → all reads stay in config-3 range.
  - Second load starts at the `done` cycle (accepted in IDLE) and uses the `config_sel` present then.
- `reset_n` low at cycle 300 (mid-WR) → `table_we`, `busy`, `cpu_hold` drop asynchronously; `table_valid`=0; no `done`.
  - Restart with `config_sel`=0 → reads begin at address 0x000, byte 0.
- `start` pulsed at cycles 10, 400 and 768 during a load → ignored, exactly one `done`.
  - A `start` in the `done` cycle begins a new load: RD the next cycle, with `table_valid` falling at that edge.
- Configuration 15 (all-ones image, `CONFIG_BITS`=4) → addresses 0x780..0x7FF; all 512 writes carry `table_val`=0b11.

Source files
------------

// File: rtl/enable_table_loader_if.sv
// Signal bundle between the enable-table loader, the configuration memory
// and the enable-table write port. The loader drives the master modport.
//
// Handshake: `start` is a request that the loader samples only while idle;
// `busy` high means the loader is not ready and further requests are
// dropped. `cfg_rd_en` is a read strobe whose data returns on
// `cfg_rd_data` exactly one cycle later with no back-pressure.
// `table_we` is a single-cycle write strobe qualifying `table_write_addr`
// and `table_val`.
interface enable_table_loader_if #(
    parameter int CONFIG_BITS   = 4,
    parameter int CFG_ADDR_BITS = CONFIG_BITS + 7
);
    logic                     start;
    logic [CONFIG_BITS-1:0]   config_sel;
    logic                     cfg_rd_en;
    logic [CFG_ADDR_BITS-1:0] cfg_rd_addr;
    logic [7:0]               cfg_rd_data;
    logic                     table_we;
    logic [8:0]               table_write_addr;
    logic [1:0]               table_val;
    logic                     busy;
    logic                     cpu_hold;
    logic                     done;
    logic                     table_valid;

    modport master (
        input  start, config_sel, cfg_rd_data,
        output cfg_rd_en, cfg_rd_addr, table_we, table_write_addr, table_val,
        output busy, cpu_hold, done, table_valid
    );

    modport slave (
        output start, config_sel, cfg_rd_data,
        input  cfg_rd_en, cfg_rd_addr, table_we, table_write_addr, table_val,
        input  busy, cpu_hold, done, table_valid
    );
endinterface

// File: rtl/enable_table_loader.sv
// Copies the 128-byte image of one stored configuration into the 512-entry
// RAM/bus enable table, four 2-bit entries per byte, holding the CPU off
// the bus for the whole load. Per byte: RD, CAP, then four WR cycles.
module enable_table_loader #(
    parameter int CONFIG_BITS   = 4,
    parameter int CFG_ADDR_BITS = CONFIG_BITS + 7
) (
    input  logic                  fpga_clk,
    input  logic                  reset_n,
    enable_table_loader_if.master bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_WR   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             k_q, k_d;
    logic [6:0]             byte_idx_q, byte_idx_d;
    logic [CONFIG_BITS-1:0] config_sel_q, config_sel_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   done_q, done_d;
    logic                   table_valid_q, table_valid_d;

    // State and datapath registers; reset abandons any load in progress.
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            k_q           <= 2'd0;
            byte_idx_q    <= 7'd0;
            config_sel_q  <= '0;
            shreg_q       <= 8'd0;
            done_q        <= 1'b0;
            table_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            byte_idx_q    <= byte_idx_d;
            config_sel_q  <= config_sel_d;
            shreg_q       <= shreg_d;
            done_q        <= done_d;
            table_valid_q <= table_valid_d;
        end
    end

    // Next-state logic: walk bytes 0..127, four entry writes per byte.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        byte_idx_d    = byte_idx_q;
        config_sel_d  = config_sel_q;
        shreg_d       = shreg_q;
        done_d        = 1'b0;
        table_valid_d = table_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d       = S_RD;
                    config_sel_d  = bus.config_sel;
                    byte_idx_d    = 7'd0;
                    table_valid_d = 1'b0;
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                // Read data is valid now, one cycle after the strobe.
                state_d = S_WR;
                shreg_d = bus.cfg_rd_data;
                k_d     = 2'd0;
            end
            S_WR: begin
                // Entry k is always in the low two bits after k shifts.
                shreg_d = {2'b00, shreg_q[7:2]};
                k_d     = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    if (byte_idx_q == 7'd127) begin
                        state_d       = S_IDLE;
                        done_d        = 1'b1;
                        table_valid_d = 1'b1;
                    end else begin
                        state_d    = S_RD;
                        byte_idx_d = byte_idx_q + 7'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from registers; nothing passes through from
    // start or cfg_rd_data. The read address only changes on entry to RD,
    // so it naturally holds its last value elsewhere.
    assign bus.cfg_rd_en        = (state_q == S_RD);
    assign bus.cfg_rd_addr      = CFG_ADDR_BITS'({config_sel_q, byte_idx_q});
    assign bus.table_we         = (state_q == S_WR);
    assign bus.table_write_addr = (state_q == S_WR) ? {byte_idx_q, k_q} : 9'd0;
    assign bus.table_val        = (state_q == S_WR) ? shreg_q[1:0] : 2'd0;
    assign bus.busy             = (state_q != S_IDLE);
    assign bus.cpu_hold         = (state_q != S_IDLE);
    assign bus.done             = done_q;
    assign bus.table_valid      = table_valid_q;
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_enable_table_loader.sv
// Directed bench for enable_table_loader: a configuration-memory model,
// a write scoreboard fed with the expected entry stream at each load start,
// and a linear sequence of load, hold, reset and restart scenarios.
module tb_enable_table_loader;

  localparam int CB = 4;
  localparam int AB = CB + 7;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbg_state;

  enable_table_loader_if #(.CONFIG_BITS(CB), .CFG_ADDR_BITS(AB)) bus();

  enable_table_loader #(.CONFIG_BITS(CB), .CFG_ADDR_BITS(AB)) dut (
    .fpga_clk    (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- configuration memory model ----------------
  logic [7:0] mem [0:(1<<AB)-1];

  // Data is only meaningful in the cycle after the strobe; noise otherwise.
  always @(posedge clk) begin
    if (bus.cfg_rd_en) bus.cfg_rd_data <= mem[bus.cfg_rd_addr];
    else               bus.cfg_rd_data <= 8'($urandom);
  end

  // ---------------- scoreboard state ----------------
  logic [10:0] exp_q[$];
  logic [1:0]  tbl [0:511];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc_n      = 0;
  int          wr_cnt, rd_cnt, rd_oor, done_cnt, busy_cnt;
  logic [AB-1:0] first_rd, last_rd;
  logic [CB-1:0] exp_cfg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {4'b0, bus.busy, bus.cpu_hold, bus.done, bus.table_valid, bus.table_we,
            bus.cfg_rd_en, bus.cfg_rd_addr, bus.table_write_addr, bus.table_val};
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.cfg_rd_en) begin
        if (rd_cnt == 0) first_rd = bus.cfg_rd_addr;
        last_rd = bus.cfg_rd_addr;
        rd_cnt++;
        if (bus.cfg_rd_addr[AB-1:7] !== exp_cfg) rd_oor++;
      end
      if (bus.table_we) begin
        logic [10:0] e;
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check("table_write", {21'b0, bus.table_write_addr, bus.table_val}, {21'b0, e});
        tbl[bus.table_write_addr] = bus.table_val;
        wr_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; rd_oor = 0; done_cnt = 0; busy_cnt = 0;
    first_rd = '0; last_rd = '0;
  endtask

  // Expected entry stream for a full load of configuration cfg.
  task automatic push_load(input logic [CB-1:0] cfg);
    for (int b = 0; b < 128; b++) begin
      logic [7:0] d;
      logic [6:0] b7;
      b7 = 7'(b);
      d  = mem[{cfg, b7}];
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({b7, 2'(k), d[2*k+1 -: 2]});
      end
    end
  endtask

  // Called in the cycle right after the accepting edge.
  task automatic begin_load(input logic [CB-1:0] cfg);
    cyc_n = 1;
    clear_stats();
    exp_cfg = cfg;
    push_load(cfg);
  endtask

  task automatic pulse_start(input logic [CB-1:0] cfg);
    bus.config_sel = cfg;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    while (bus.done !== 1'b1 && cyc_n < 1000) tick();
    check("done_cycle", cyc_n, 769);
    check("done_pulse", bus.done, 1'b1);
    check("busy_in_done_cycle", bus.busy, 1'b0);
  endtask

  task automatic check_full_load(input logic [AB-1:0] first_a);
    check("write_count", wr_cnt, 512);
    check("read_count", rd_cnt, 128);
    check("busy_cycles", busy_cnt, 768);
    check("first_read_addr", first_rd, first_a);
    check("last_read_addr", last_rd, first_a + AB'(127));
    check("reads_out_of_config", rd_oor, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    check("table_valid_at_done", bus.table_valid, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bad;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.config_sel = '0;
    exp_cfg = '0;
    clear_stats();
    for (int a = 0; a < (1 << AB); a++) begin
      if ((a >> 7) == 3)       mem[a] = 8'(a & 127);
      else if ((a >> 7) == 15) mem[a] = 8'hFF;
      else                     mem[a] = 8'($urandom);
    end
    for (int i = 0; i < 512; i++) tbl[i] = 2'b00;

    repeat (3) tick();
    check("reset_outputs", out_vec(), 32'd0);
    check("reset_state", dbg_state, 2'd0);
    reset_n = 1'b1;
    clear_stats();

    // Idle after reset: everything low, no reads.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outputs", out_vec(), 32'd0);
    end
    check("idle_no_reads", rd_cnt, 0);

    // Full load of configuration 3 (byte b holds b).
    pulse_start(4'd3);
    begin_load(4'd3);
    check("c3_first_rd_en", bus.cfg_rd_en, 1'b1);
    check("c3_first_rd_addr", bus.cfg_rd_addr, 11'h180);
    check("c3_busy", {bus.busy, bus.cpu_hold}, 2'b11);
    wait_done();
    check_full_load(11'h180);
    check("c3_entry_511", tbl[511], 2'b01);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (tbl[i] !== 2'(((i >> 2) >> (2 * (i & 3))) & 3)) bad++;
    end
    check("c3_table_contents", bad, 0);
    tick();
    check("c3_done_one_cycle", bus.done, 1'b0);
    check("c3_table_valid_holds", bus.table_valid, 1'b1);
    check("c3_rd_addr_holds", bus.cfg_rd_addr, 11'h1FF);

    // Start held high; config_sel changes mid-load and must not be seen.
    bus.config_sel = 4'd3;
    bus.start = 1'b1;
    tick();
    begin_load(4'd3);
    while (cyc_n < 100) tick();
    bus.config_sel = 4'd5;
    wait_done();
    check("hold_reads_in_config3", rd_oor, 0);
    check("hold_last_read", last_rd, 11'h1FF);
    check("hold_scoreboard_drained", exp_q.size(), 0);
    tick();
    bus.start = 1'b0;
    begin_load(4'd5);
    check("c5_rd_en", bus.cfg_rd_en, 1'b1);
    check("c5_rd_addr", bus.cfg_rd_addr, 11'h280);
    check("c5_table_valid_fell", bus.table_valid, 1'b0);

    // Asynchronous reset in the middle of a WR cycle.
    while (cyc_n < 300) tick();
    check("pre_reset_we", bus.table_we, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_we_drop", bus.table_we, 1'b0);
    check("rst_busy_drop", {bus.busy, bus.cpu_hold}, 2'b00);
    check("rst_table_valid", bus.table_valid, 1'b0);
    check("rst_done", bus.done, 1'b0);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("post_rst_no_done", done_cnt, 0);
    check("post_rst_idle", out_vec() & 32'h0FFF_FFFF & ~32'h0000_0000, {4'b0, 6'b0, 11'h000, 11'h0});

    // Restart with configuration 0.
    pulse_start(4'd0);
    begin_load(4'd0);
    check("c0_rd_addr", bus.cfg_rd_addr, 11'h000);
    check("c0_rd_en", bus.cfg_rd_en, 1'b1);
    wait_done();
    check_full_load(11'h000);
    tick();

    // Starts during a load are ignored; a start in the done cycle is taken.
    pulse_start(4'd7);
    begin_load(4'd7);
    while (cyc_n < 10) tick();
    pulse_start(4'd9);
    while (cyc_n < 400) tick();
    pulse_start(4'd9);
    while (cyc_n < 768) tick();
    check("c7_no_early_done", done_cnt, 0);
    check("c7_busy_768", bus.busy, 1'b1);
    pulse_start(4'd9);
    check("c7_done_cycle", cyc_n, 769);
    check("c7_done_pulse", bus.done, 1'b1);
    check("c7_reads_in_config7", rd_oor, 0);
    check("c7_writes", wr_cnt, 512);
    check("c7_scoreboard_drained", exp_q.size(), 0);
    bus.config_sel = 4'd15;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("c7_single_done", done_cnt, 1);
    begin_load(4'd15);
    check("c15_rd_en_next", bus.cfg_rd_en, 1'b1);
    check("c15_rd_addr", bus.cfg_rd_addr, 11'h780);
    check("c15_table_valid_fell", bus.table_valid, 1'b0);
    wait_done();
    check_full_load(11'h780);
    bad = 0;
    for (int i = 0; i < 512; i++) if (tbl[i] !== 2'b11) bad++;
    check("c15_all_ones", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
